stream_parity_checker: RTL

- Streaming, parametrised parity checker; the successor of the team's 4-bit combinational checker.
- Accepts DATA_W-bit words, each with a transmitted parity bit, over a valid/ready handshake.
- Groups FRAME_LEN words into a frame and checks each word in even or odd mode.
- Emits a registered per-frame result (word error mask, frame error, frame parity) with backpressure; keeps a saturating count of errored frames.
- Sits between a link receiver and the frame consumer.

---
 rtl/parity_pkg.sv | 29 ++
 rtl/parity_word_check.sv | 28 ++
 rtl/stream_parity_checker.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared types, constants and helpers for the stream parity checker.
//   state_t       : frame FSM states (COLLECT words, HOLD result)
//   MODE_EVEN/ODD : values of the odd_mode input
//   word_parity() : expected parity bit of one word in the given mode
// -----------------------------------------------------------------------------
package parity_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

  // Widest data word word_parity() accepts. Callers zero-extend narrower
  // words, which leaves the XOR reduction unchanged.
  localparam int PARITY_MAX_W = 256;

  // Expected parity bit: reduction XOR of the data, inverted in odd mode so
  // that data plus parity always carries an odd number of ones.
  function automatic logic word_parity(input logic [PARITY_MAX_W-1:0] data,
                                       input logic                    mode);
    return (^data) ^ mode;
  endfunction

endpackage

// File: rtl/parity_word_check.sv
// -----------------------------------------------------------------------------
// parity_word_check
// Purely combinational single-word parity check.
//   data     : input  [DATA_W] data word (DATA_W <= PARITY_MAX_W)
//   par_in   : input  transmitted parity bit
//   mode     : input  MODE_EVEN / MODE_ODD
//   calc_par : output parity bit the word should carry in this mode
//   err      : output 1 when par_in disagrees with calc_par
// -----------------------------------------------------------------------------
module parity_word_check
  import parity_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par_in,
  input  logic              mode,
  output logic              calc_par,
  output logic              err
);

  logic [PARITY_MAX_W-1:0] data_ext;

  assign data_ext = PARITY_MAX_W'(data);
  assign calc_par = word_parity(data_ext, mode);
  assign err      = (calc_par != par_in);

endmodule

// File: rtl/stream_parity_checker.sv
// -----------------------------------------------------------------------------
// stream_parity_checker
// Streaming parity checker. Collects FRAME_LEN words over a valid/ready
// handshake, checks each word against its transmitted parity bit in even or
// odd mode, and presents one registered result per frame with backpressure.
//
// Ports:
//   clk, rst_n      : rising-edge clock, synchronous active-low reset
//   odd_mode        : parity mode, sampled on the first beat of each frame
//   in_valid/ready  : input handshake; in_data [DATA_W], in_par
//   out_valid/ready : result handshake
//   out_word_err    : [FRAME_LEN] bit i = word i of the frame failed
//   out_frame_err   : OR of out_word_err
//   out_frame_par   : XOR of every data bit in the frame XOR latched mode
//   err_count       : [CNT_W] saturating count of errored frames
//
// Optional build macro PARITY_STICKY_ERR_EN adds:
//   clr_sticky      : input, clears err_sticky (a simultaneous set wins)
//   err_sticky      : output, set by any errored frame result
//
// Throughput: one frame per FRAME_LEN+1 cycles; the result always spends at
// least one cycle in HOLD before new words are taken.
// -----------------------------------------------------------------------------
module stream_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 odd_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_par,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAME_LEN-1:0] out_word_err,
  output logic                 out_frame_err,
  output logic                 out_frame_par,
  output logic [CNT_W-1:0]     err_count
`ifdef PARITY_STICKY_ERR_EN
  ,
  input  logic                 clr_sticky,
  output logic                 err_sticky
`endif
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx;
  logic                 mode_q;
  logic [FRAME_LEN-1:0] mask_acc;
  logic                 par_acc;

  logic                 accept;
  logic                 last_beat;
  logic                 load;
  logic                 first_beat;
  logic                 mode_cur;
  logic                 calc_par;
  logic                 word_err;
  logic [FRAME_LEN-1:0] mask_nxt;
  logic                 par_nxt;
  logic                 frame_err_nxt;

  // ---------------------------------------------------------------------------
  // Per-beat datapath
  // ---------------------------------------------------------------------------
  assign accept     = in_valid && in_ready;
  assign first_beat = (idx == '0);
  assign last_beat  = (idx == LAST_IDX);
  assign load       = accept && last_beat;

  // Beat 0 uses the live mode input; later beats use the value latched then.
  assign mode_cur = first_beat ? odd_mode : mode_q;

  parity_word_check #(
    .DATA_W(DATA_W)
  ) u_word_check (
    .data    (in_data),
    .par_in  (in_par),
    .mode    (mode_cur),
    .calc_par(calc_par),
    .err     (word_err)
  );

  // Accumulators restart on beat 0, so a frame never inherits stale state.
  // calc_par ^ mode_cur strips the mode back out, leaving the pure data XOR.
  assign mask_nxt      = (first_beat ? '0 : mask_acc)
                       | (word_err ? (FRAME_LEN'(1) << idx) : '0);
  assign par_nxt       = (first_beat ? 1'b0 : par_acc) ^ calc_par ^ mode_cur;
  assign frame_err_nxt = |mask_nxt;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (load) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat index, mode latch and accumulators
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      mode_q   <= MODE_EVEN;
      mask_acc <= '0;
      par_acc  <= 1'b0;
    end else if (accept) begin
      idx      <= last_beat ? '0 : idx + IDX_W'(1);
      mask_acc <= mask_nxt;
      par_acc  <= par_nxt;
      if (first_beat) mode_q <= odd_mode;
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers and errored-frame counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_word_err  <= '0;
      out_frame_err <= 1'b0;
      out_frame_par <= 1'b0;
      err_count     <= '0;
    end else if (load) begin
      out_word_err  <= mask_nxt;
      out_frame_err <= frame_err_nxt;
      out_frame_par <= par_nxt ^ mode_cur;
      // Saturate at all-ones rather than wrapping back to zero.
      if (frame_err_nxt && (err_count != '1)) err_count <= err_count + CNT_W'(1);
    end
  end

`ifdef PARITY_STICKY_ERR_EN
  // Sticky error flag: a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n)                       err_sticky <= 1'b0;
    else if (load && frame_err_nxt)   err_sticky <= 1'b1;
    else if (clr_sticky)              err_sticky <= 1'b0;
  end
`else
  // No sticky error flag in this build; err_count is the only error history.
`endif

endmodule
